// File: rtl/if_id_queue_if.sv
// IF->ID queue handshake bundle: write side from fetch, read side to decode, plus flush.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            i_flush;
    logic            i_wr_valid;
    logic [95:0]     i_if_id_regs;
    logic            o_wr_ready;
    logic            o_if_stall;
    logic            o_rd_valid;
    logic [95:0]     o_if_id_regs;
    logic            i_rd_ready;
    logic [CntW-1:0] o_count;

    // Driver of the queue (fetch/decode environment)
    modport master (
        output i_flush, i_wr_valid, i_if_id_regs, i_rd_ready,
        input  o_wr_ready, o_if_stall, o_rd_valid, o_if_id_regs, o_count
    );

    // The queue itself
    modport slave (
        input  i_flush, i_wr_valid, i_if_id_regs, i_rd_ready,
        output o_wr_ready, o_if_stall, o_rd_valid, o_if_id_regs, o_count
    );
endinterface

// File: rtl/if_id_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Shows a NOP bubble when empty; flush discards everything, including a same-cycle push.
module if_id_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic           i_clk,
    input logic           i_rst_n,
    if_id_queue_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [95:0]     mem [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_ready;
    logic            rd_valid;
    logic            push;
    logic            pop;

    // Handshake qualifiers derived only from registered occupancy
    always_comb begin
        wr_ready = (count_q < CntW'(DEPTH));
        rd_valid = (count_q != '0);
        push     = bus.i_wr_valid & wr_ready;
        pop      = rd_valid & bus.i_rd_ready;
    end

    // Next-state pointers and occupancy; flush overrides push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; array is intentionally not reset
    always_ff @(posedge i_clk) begin
        if (push && !bus.i_flush) begin
            mem[wr_ptr_q] <= bus.i_if_id_regs;
        end
    end

    // Outputs: head is a combinational read so a pushed beat is visible right after its edge
    always_comb begin
        bus.o_wr_ready   = wr_ready;
        bus.o_if_stall   = ~wr_ready;
        bus.o_rd_valid   = rd_valid;
        bus.o_count      = count_q;
        bus.o_if_id_regs = rd_valid ? mem[rd_ptr_q] : {NOP_INST, 64'd0};
    end

    // Occupancy invariants
    a_count_max : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        count_q <= CntW'(DEPTH));
    a_no_push_full : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && (count_q == CntW'(DEPTH))));
    // Full wraps the pointer difference to zero, which matches count's low bits
    a_ptr_count : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        count_q[PtrW-1:0] == PtrW'(wr_ptr_q - rd_ptr_q));
endmodule
